bin_to_bcd_seq: RTL and testbench

Sequential binary-to-BCD encoder using shift-and-add-3 (double dabble), one bit per clock. It is the producer side of the packed 10-digit BCD bus that the BCD-to-decimal block consumes. A binary word is accepted over a valid/ready handshake. NDIG packed BCD digits are returned over a second valid/ready handshake, with an overflow flag.

---
 rtl/bin_to_bcd_seq.sv | 129 ++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD encoder, one bit per clock, valid/ready on both sides.
// Optional BIN_TO_BCD_DIGCNT_EN adds ndig_out (count of significant digits) alongside bcd_out.
module bin_to_bcd_seq #(
  parameter int BIN_W = 32,
  parameter int NDIG  = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [BIN_W-1:0]           bin_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [4*NDIG-1:0]          bcd_out,
  output logic                       overflow,
`ifdef BIN_TO_BCD_DIGCNT_EN
  output logic [$clog2(NDIG+1)-1:0]  ndig_out,
`endif
  output logic                       busy
);

  localparam int CW = $clog2(BIN_W + 1);
  localparam int BW = 4 * NDIG;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [BW-1:0]    acc_q, acc_d;
  logic [BW-1:0]    bcd_q, bcd_d;
  logic [BW-1:0]    adj, acc_sh;
  logic             ovf_acc_q, ovf_acc_d;
  logic             ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             finish;

  always_comb begin
    adj = acc_q;
    for (int i = 0; i < NDIG; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
  end

  // Binary MSB enters digit 0; the top digit's MSB falls out into the overflow accumulator.
  assign acc_sh = {adj[BW-2:0], bin_q[BIN_W-1]};
  assign finish = (state_q == S_SHIFT) && (cnt_q == CW'(1));

  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    acc_d     = acc_q;
    ovf_acc_d = ovf_acc_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          bin_d     = bin_in;
          acc_d     = '0;
          ovf_acc_d = 1'b0;
          cnt_d     = CW'(BIN_W);
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        acc_d     = acc_sh;
        bin_d     = {bin_q[BIN_W-2:0], 1'b0};
        ovf_acc_d = ovf_acc_q | adj[BW-1];
        cnt_d     = cnt_q - CW'(1);
        if (finish) begin
          bcd_d   = acc_sh;
          ovf_d   = ovf_acc_q | adj[BW-1];
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      bin_q     <= '0;
      acc_q     <= '0;
      ovf_acc_q <= 1'b0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      acc_q     <= acc_d;
      ovf_acc_q <= ovf_acc_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
    end
  end

`ifdef BIN_TO_BCD_DIGCNT_EN
  localparam int NW = $clog2(NDIG + 1);
  logic [NW-1:0] ndig_q, ndig_new;

  always_comb begin
    ndig_new = NW'(1);
    for (int i = 0; i < NDIG; i++) begin
      if (acc_sh[4*i +: 4] != 4'd0) ndig_new = NW'(i + 1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      ndig_q <= '0;
    else if (finish) ndig_q <= ndig_new;
  end

  assign ndig_out = ndig_q;
`endif

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q == S_SHIFT);
  assign out_valid = (state_q == S_DONE);
  assign bcd_out   = bcd_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Randomized bench for bin_to_bcd_seq: default 32-bit/10-digit instance plus a 16-bit/4-digit
// instance for overflow; results compared against a divide-by-ten reference model.
module tb_bin_to_bcd_seq;
  localparam int BW  = 32;
  localparam int ND  = 10;
  localparam int SBW = 16;
  localparam int SND = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic             in_valid, in_ready, out_valid, out_ready, overflow, busy;
  logic [BW-1:0]    bin_in;
  logic [4*ND-1:0]  bcd_out;
  logic             s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_overflow, s_busy;
  logic [SBW-1:0]   s_bin_in;
  logic [4*SND-1:0] s_bcd_out;
`ifdef BIN_TO_BCD_DIGCNT_EN
  logic [3:0]       ndig_out;
  logic [2:0]       s_ndig_out;
`endif

  int vectors = 0;
  int miscompares = 0;

  bin_to_bcd_seq #(.BIN_W(BW), .NDIG(ND)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .bin_in(bin_in),
    .out_valid(out_valid), .out_ready(out_ready), .bcd_out(bcd_out), .overflow(overflow),
`ifdef BIN_TO_BCD_DIGCNT_EN
    .ndig_out(ndig_out),
`endif
    .busy(busy)
  );

  bin_to_bcd_seq #(.BIN_W(SBW), .NDIG(SND)) dut_s (
    .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_ready(s_in_ready), .bin_in(s_bin_in),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .bcd_out(s_bcd_out), .overflow(s_overflow),
`ifdef BIN_TO_BCD_DIGCNT_EN
    .ndig_out(s_ndig_out),
`endif
    .busy(s_busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Decimal digits by repeated division; anything left above nd digits is overflow.
  function automatic void ref_conv(input longint unsigned v, input int nd,
                                   output logic [63:0] bcd, output logic ovf, output int used);
    bcd  = '0;
    used = 1;
    for (int d = 0; d < nd; d++) begin
      bcd[4*d +: 4] = 4'(v % 10);
      if (v % 10 != 0) used = d + 1;
      v = v / 10;
    end
    ovf = (v != 0);
  endfunction

  task automatic convert(input logic [31:0] v, input int hold, input string tag);
    logic [63:0] eb;
    logic        eo;
    int          en, lat;
    ref_conv(64'(v), ND, eb, eo, en);
    @(negedge clk);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    bin_in   = v;
    @(negedge clk);
    in_valid = 1'b0;
    bin_in   = $urandom;
    chk({tag, "_in_ready_drop"}, 64'(in_ready), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    lat = 0;
    while (!out_valid && lat < BW + 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(BW));
    chk({tag, "_bcd"}, 64'(bcd_out), eb);
    chk({tag, "_ovf"}, 64'(overflow), 64'(eo));
`ifdef BIN_TO_BCD_DIGCNT_EN
    chk({tag, "_ndig"}, 64'(ndig_out), 64'(en));
`endif
    for (int h = 0; h < hold; h++) begin
      in_valid = h[0];
      bin_in   = $urandom;
      @(negedge clk);
      chk({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
      chk({tag, "_hold_ready"}, 64'(in_ready), 64'd0);
      chk({tag, "_hold_bcd"}, 64'(bcd_out), eb);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_release_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_release_idle"}, 64'(in_ready), 64'd1);
    chk({tag, "_bcd_kept"}, 64'(bcd_out), eb);
  endtask

  task automatic s_convert(input logic [15:0] v, input string tag);
    logic [63:0] eb;
    logic        eo;
    int          en, lat;
    ref_conv(64'(v), SND, eb, eo, en);
    @(negedge clk);
    s_in_valid = 1'b1;
    s_bin_in   = v;
    @(negedge clk);
    s_in_valid = 1'b0;
    lat = 0;
    while (!s_out_valid && lat < SBW + 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(SBW));
    chk({tag, "_bcd"}, 64'(s_bcd_out), eb);
    chk({tag, "_ovf"}, 64'(s_overflow), 64'(eo));
`ifdef BIN_TO_BCD_DIGCNT_EN
    chk({tag, "_ndig"}, 64'(s_ndig_out), 64'(en));
`endif
    s_out_ready = 1'b1;
    @(negedge clk);
    s_out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] q[$];
    logic [31:0] w;
    logic [63:0] eb;
    logic        eo;
    int          en, sent, got, last, cyc, saw;

    reset = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; bin_in = '0;
    s_in_valid = 1'b0; s_out_ready = 1'b0; s_bin_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_bcd", 64'(bcd_out), 64'd0);
`ifdef BIN_TO_BCD_DIGCNT_EN
    chk("rst_ndig", 64'(ndig_out), 64'd0);
`endif
    reset = 1'b1;

    convert(32'd12345, 0, "t12345");
    convert(32'hFFFF_FFFF, 0, "tmax");
    convert(32'd0, 0, "tzero");
    convert($urandom, 20, "tbackpressure");
    convert(32'd999, 0, "t999");

    // Abort a conversion part-way with an asynchronous reset.
    @(negedge clk);
    in_valid = 1'b1;
    bin_in   = 32'd987654321;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    #1 reset = 1'b0;
    #1;
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_bcd", 64'(bcd_out), 64'd0);
    chk("abort_ovf", 64'(overflow), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    saw = 0;
    repeat (50) begin
      @(negedge clk);
      if (out_valid || busy) saw = 1;
    end
    chk("abort_no_spurious", 64'(saw), 64'd0);
    convert(32'd7, 0, "t7");

    s_convert(16'd65535, "s65535");
    s_convert(16'd9999, "s9999");
    s_convert(16'd10000, "s10000");
    s_convert(16'd0, "szero");
    for (int i = 0; i < 8; i++) s_convert(16'($urandom), "srand");

    // Continuous stream: in_valid stays high, with garbage data whenever the DUT is not ready.
    out_ready = 1'b1;
    sent = 0; got = 0; last = -1; cyc = 0;
    while (got < 300 && cyc < 300 * (BW + 2) + 200) begin
      @(negedge clk);
      cyc++;
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("stream_dup", 64'd1, 64'd0);
        end else begin
          w = q.pop_front();
          ref_conv(64'(w), ND, eb, eo, en);
          chk("stream_bcd", 64'(bcd_out), eb);
          chk("stream_ovf", 64'(overflow), 64'(eo));
        end
        if (last >= 0) chk("stream_gap", 64'(cyc - last), 64'(BW + 2));
        last = cyc;
        got++;
      end
      if (in_ready && sent < 300) begin
        case ($urandom_range(0, 3))
          0:       w = 32'($urandom_range(0, 20));
          1:       w = 32'hFFFF_FFFF - 32'($urandom_range(0, 5));
          default: w = $urandom;
        endcase
        q.push_back(w);
        in_valid = 1'b1;
        bin_in   = w;
        sent++;
      end else begin
        in_valid = (sent < 300);
        bin_in   = $urandom;
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    chk("stream_count", 64'(got), 64'd300);
    chk("stream_leftover", 64'(q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
